// File: rtl/free_list_pkg.sv
// Shared rename constants and types: register-file sizes, PR index type and
// free-list pointer type, used by the free list, map table, ROB and hazard unit.
package free_list_pkg;

    localparam int PR_NUM   = 64;
    localparam int ARCH_NUM = 32;
    localparam int PR_W     = $clog2(PR_NUM);
    localparam int DEPTH    = PR_NUM - ARCH_NUM;
    localparam int PTR_W    = $clog2(DEPTH);

    typedef logic [PR_W-1:0]  pr_idx_t;
    typedef logic [PTR_W-1:0] ptr_t;

    // PR held by free-list slot 'slot' straight out of reset.
    function automatic pr_idx_t reset_pr(input int slot);
        return pr_idx_t'(ARCH_NUM + slot);
    endfunction

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of unmapped PRs for the rename stage.
// Optional same-cycle retire-to-dispatch bypass while empty: FREELIST_BYPASS_EN.
module free_list
    import free_list_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hazard_stall,
    input  logic            RegDest,
    input  logic            recover,
    output logic [PR_W-1:0] p_rd_new,
    output logic            empty,
    output logic [PR_W-1:0] free_cnt,
    input  logic            free_en,
    input  logic [PR_W-1:0] free_prd,
    input  logic            RegDest_ROB,
    input  logic [PR_W-1:0] recover_prd
);

    localparam logic [PR_W-1:0] FULL_CNT = PR_W'(DEPTH);

    ptr_t            head_reg;
    ptr_t            tail_reg;
    logic [PR_W-1:0] count_reg;
    pr_idx_t         slot_q [DEPTH];

    ptr_t            head_dec;
    logic            full;
    logic            bypass;
    logic            alloc;
    logic            push_front;
    logic            push_back;
    logic            drop_free;
    logic            drop_front;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == FULL_CNT);
    assign free_cnt = count_reg;
    assign head_dec = head_reg - 1'b1;

`ifdef FREELIST_BYPASS_EN
    // Empty list: a retiring PR is handed straight to the dispatching instruction.
    assign bypass = empty & free_en & RegDest & ~hazard_stall & ~recover;
`else
    assign bypass = 1'b0;
`endif

    assign alloc      = RegDest & ~hazard_stall & ~recover & ~empty;
    assign push_front = recover & RegDest_ROB & ~full;
    // With only one slot left, a recovery push-front takes it and the free is dropped.
    assign push_back  = free_en & ~bypass & ~full
                      & ~(push_front & (count_reg == FULL_CNT - 1'b1));

    assign drop_free  = free_en & ~bypass & ~push_back;
    assign drop_front = recover & RegDest_ROB & full;

    assign p_rd_new = bypass ? free_prd : slot_q[head_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= FULL_CNT;
        end else begin
            if (push_front)
                head_reg <= head_dec;
            else if (alloc)
                head_reg <= head_reg + 1'b1;
            if (push_back)
                tail_reg <= tail_reg + 1'b1;
            count_reg <= count_reg + PR_W'(push_back) + PR_W'(push_front) - PR_W'(alloc);
        end
    end

    // Head-side and tail-side writes never hit the same slot: push_back yields when they would.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        pr_idx_t slot_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                slot_reg <= reset_pr(gi);
            else if (push_front && head_dec == ptr_t'(gi))
                slot_reg <= recover_prd;
            else if (push_back && tail_reg == ptr_t'(gi))
                slot_reg <= free_prd;
        end

        assign slot_q[gi] = slot_reg;
    end

    overflow_dropped: assert property (@(posedge clk) disable iff (rst) !(drop_free || drop_front));

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios with literal expectations plus a random
// phase, all continuously compared against a queue model of the free list.
module tb_free_list;
    import free_list_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            hazard_stall = 1'b0;
    logic            RegDest      = 1'b0;
    logic            recover      = 1'b0;
    logic [PR_W-1:0] p_rd_new;
    logic            empty;
    logic [PR_W-1:0] free_cnt;
    logic            free_en      = 1'b0;
    logic [PR_W-1:0] free_prd     = '0;
    logic            RegDest_ROB  = 1'b0;
    logic [PR_W-1:0] recover_prd  = '0;

    int total = 0;
    int bad   = 0;

    free_list dut (
        .clk         (clk),
        .rst         (rst),
        .hazard_stall(hazard_stall),
        .RegDest     (RegDest),
        .recover     (recover),
        .p_rd_new    (p_rd_new),
        .empty       (empty),
        .free_cnt    (free_cnt),
        .free_en     (free_en),
        .free_prd    (free_prd),
        .RegDest_ROB (RegDest_ROB),
        .recover_prd (recover_prd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the free list as an ordered queue; front is the next PR handed out.
    int mq[$];
    int m_sz;
    bit m_alloc, m_front, m_free, m_byp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            for (int i = 0; i < DEPTH; i++) mq.push_back(ARCH_NUM + i);
        end else begin
            m_sz    = mq.size();
            m_byp   = 1'b0;
`ifdef FREELIST_BYPASS_EN
            m_byp   = (m_sz == 0) && free_en && RegDest && !hazard_stall && !recover;
`endif
            m_alloc = RegDest && !hazard_stall && !recover && (m_sz != 0);
            m_front = recover && RegDest_ROB && (m_sz < DEPTH);
            m_free  = free_en && !m_byp && (m_sz + int'(m_front) < DEPTH);
            if (m_alloc) void'(mq.pop_front());
            if (m_front) mq.push_front(int'(recover_prd));
            if (m_free)  mq.push_back(int'(free_prd));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_free_cnt", int'(free_cnt), mq.size());
            chk("model_empty", int'(empty), int'(mq.size() == 0));
            if (mq.size() != 0)
                chk("model_p_rd_new", int'(p_rd_new), mq[0]);
`ifdef FREELIST_BYPASS_EN
            else if (free_en && RegDest && !hazard_stall && !recover)
                chk("model_bypass", int'(p_rd_new), int'(free_prd));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hazard_stall = 1'b0;
        RegDest      = 1'b0;
        recover      = 1'b0;
        free_en      = 1'b0;
        RegDest_ROB  = 1'b0;
    endtask

    int drain_exp[26];

    initial begin
        rst = 1'b1;
        #12 rst = 1'b0;
        @(negedge clk);
        chk("reset_p_rd_new", int'(p_rd_new), 32);
        chk("reset_free_cnt", int'(free_cnt), 32);
        chk("reset_empty", int'(empty), 0);
        $display("reset: p_rd_new=%0d free_cnt=%0d empty=%0d", p_rd_new, free_cnt, empty);

        // Stall gating, then recovery gating
        step(); RegDest = 1'b1; hazard_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_p_rd_new", int'(p_rd_new), 32);
            chk("stall_free_cnt", int'(free_cnt), 32);
            step();
        end
        hazard_stall = 1'b0; recover = 1'b1; RegDest_ROB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("recover_gate_p_rd_new", int'(p_rd_new), 32);
            chk("recover_gate_free_cnt", int'(free_cnt), 32);
            step();
        end
        recover = 1'b0;

        // 32 consecutive allocations
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("alloc_seq", int'(p_rd_new), 32 + i);
            $display("alloc %0d: p_rd_new=%0d", i, p_rd_new);
            step();
        end
        RegDest = 1'b0;
        @(negedge clk);
        chk("drained_empty", int'(empty), 1);
        chk("drained_free_cnt", int'(free_cnt), 0);

        // Retire 5 and 7 into wrapped tail slots, then reallocate them
        step(); free_en = 1'b1; free_prd = 6'd5;
        step(); free_prd = 6'd7;
        step(); free_en = 1'b0;
        @(negedge clk);
        chk("retire_free_cnt", int'(free_cnt), 2);
        chk("retire_empty", int'(empty), 0);
        step(); RegDest = 1'b1;
        @(negedge clk); chk("realloc_first", int'(p_rd_new), 5);
        step();
        @(negedge clk); chk("realloc_second", int'(p_rd_new), 7);
        step(); RegDest = 1'b0;
        @(negedge clk); chk("realloc_empty", int'(empty), 1);

        // Reset between edges wipes state at once
        step(); rst = 1'b1;
        #1;
        chk("midreset_free_cnt", int'(free_cnt), 32);
        chk("midreset_p_rd_new", int'(p_rd_new), 32);
        chk("midreset_empty", int'(empty), 0);
        $display("mid-cycle reset: free_cnt=%0d p_rd_new=%0d", free_cnt, p_rd_new);
        #1 rst = 1'b0;

        // Recovery walk restores allocation order
        step(); RegDest = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("recov_alloc", int'(p_rd_new), 40 + i);
            step();
        end
        RegDest = 1'b0;
        @(negedge clk); chk("recov_pre_cnt", int'(free_cnt), 21);
        step(); recover = 1'b1; RegDest_ROB = 1'b1; recover_prd = 6'd42;
        step(); RegDest_ROB = 1'b0;
        @(negedge clk);
        chk("walk_hole_p_rd_new", int'(p_rd_new), 42);
        chk("walk_hole_cnt", int'(free_cnt), 22);
        step(); RegDest_ROB = 1'b1; recover_prd = 6'd41;
        step(); recover_prd = 6'd40;
        step(); idle_inputs();
        @(negedge clk);
        chk("walk_done_cnt", int'(free_cnt), 24);
        chk("walk_done_p_rd_new", int'(p_rd_new), 40);
        $display("recovery: free_cnt=%0d p_rd_new=%0d", free_cnt, p_rd_new);

        // Simultaneous alloc+free, then free+push-front
        step(); RegDest = 1'b1; free_en = 1'b1; free_prd = 6'd3;
        step(); idle_inputs();
        @(negedge clk);
        chk("alloc_free_cnt", int'(free_cnt), 24);
        chk("alloc_free_p_rd_new", int'(p_rd_new), 41);
        step(); recover = 1'b1; RegDest_ROB = 1'b1; recover_prd = 6'd40;
        free_en = 1'b1; free_prd = 6'd11;
        step(); idle_inputs();
        @(negedge clk);
        chk("free_push_cnt", int'(free_cnt), 26);
        chk("free_push_p_rd_new", int'(p_rd_new), 40);

        // Drain: 40..63 then the tail-written 3 and 11
        for (int i = 0; i < 24; i++) drain_exp[i] = 40 + i;
        drain_exp[24] = 3;
        drain_exp[25] = 11;
        step(); RegDest = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            chk("drain_seq", int'(p_rd_new), drain_exp[i]);
            step();
        end
        RegDest = 1'b0;
        @(negedge clk); chk("drain_empty", int'(empty), 1);

        // Retire into an empty list while dispatch wants a register
        step(); free_en = 1'b1; free_prd = 6'd9; RegDest = 1'b1;
        @(negedge clk);
`ifdef FREELIST_BYPASS_EN
        chk("bypass_p_rd_new", int'(p_rd_new), 9);
`endif
        chk("bypass_empty_out", int'(empty), 1);
        step(); idle_inputs();
        @(negedge clk);
`ifdef FREELIST_BYPASS_EN
        chk("bypass_free_cnt", int'(free_cnt), 0);
`else
        chk("nobypass_free_cnt", int'(free_cnt), 1);
`endif
        $display("empty-retire: free_cnt=%0d", free_cnt);

        // Random traffic, kept out of overflow
        for (int c = 0; c < 3000; c++) begin
            step();
            RegDest      = ($urandom % 2) == 0;
            hazard_stall = ($urandom % 4) == 0;
            recover      = ($urandom % 6) == 0;
            RegDest_ROB  = ($urandom % 2) == 0;
            recover_prd  = PR_W'($urandom % PR_NUM);
            free_prd     = PR_W'($urandom % PR_NUM);
            if (recover && RegDest_ROB && mq.size() >= DEPTH) RegDest_ROB = 1'b0;
            free_en = (($urandom % 3) != 0)
                      && (mq.size() + int'(recover && RegDest_ROB) < DEPTH);
            if (c % 500 == 0)
                $display("random cycle %0d: model size=%0d", c, mq.size());
        end
        step(); idle_inputs();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
